// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES round sequencer:
//   - aes_seq_state_t : sequencer FSM state encoding
//   - NR_AES128/256   : round counts for 128-bit and 256-bit keys
//   - RND_W           : width of the round index / key index
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int RND_W = 4;

    localparam logic [RND_W-1:0] NR_AES128 = 4'd10;
    localparam logic [RND_W-1:0] NR_AES256 = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } aes_seq_state_t;

endpackage

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
// Iterative AES encryption controller. Accepts one plaintext block, applies the
// initial AddRoundKey itself, then issues one round at a time to an external
// single-round datapath and returns the ciphertext over a valid/ready port.
//
// Optional feature macro: AES_SEQ_KEY256_EN
//   defined   : in_key_len selects 10 (AES-128) or 14 (AES-256) rounds
//   undefined : in_key_len ignored, always 10 rounds
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   plaintext handshake, in_data plaintext, in_key_len
//   key_idx/key_data    round-key lookup (key_data combinational on key_idx)
//   dp_valid_out        one-cycle round issue, dp_state_out state, dp_final
//   dp_valid_in         datapath result strobe, dp_state_in result
//   out_valid/out_ready ciphertext handshake, out_data ciphertext
// -----------------------------------------------------------------------------
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ROUND_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_key_len,
    output logic [RND_W-1:0]      key_idx,
    input  logic [127:0]          key_data,
    output logic                  dp_valid_out,
    output logic [DATA_WIDTH-1:0] dp_state_out,
    output logic                  dp_final,
    input  logic                  dp_valid_in,
    input  logic [DATA_WIDTH-1:0] dp_state_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    // The sequencer waits on dp_valid_in, so its timing adapts to any datapath
    // latency; ROUND_LAT only characterises the attached datapath.
    if (ROUND_LAT < 1) begin : g_round_lat_check
        $error("ROUND_LAT must be at least 1");
    end

    aes_seq_state_t          fsm_reg;
    logic [DATA_WIDTH-1:0]   state_reg;
    logic [RND_W-1:0]        rnd_reg;
    logic [RND_W-1:0]        rnd_next;
    logic [RND_W-1:0]        nr;
    logic                    in_ready_reg;
    logic                    dp_valid_out_reg;
    logic                    dp_final_reg;
    logic                    out_valid_reg;

`ifdef AES_SEQ_KEY256_EN
    logic [RND_W-1:0]        nr_reg;
    assign nr = nr_reg;
`else
    logic                    unused_key_len;
    assign nr             = NR_AES128;
    assign unused_key_len = in_key_len;
`endif

    assign rnd_next = rnd_reg + RND_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_reg          <= IDLE;
            state_reg        <= '0;
            rnd_reg          <= '0;
            in_ready_reg     <= 1'b0;
            dp_valid_out_reg <= 1'b0;
            dp_final_reg     <= 1'b0;
            out_valid_reg    <= 1'b0;
`ifdef AES_SEQ_KEY256_EN
            nr_reg           <= NR_AES128;
`endif
        end else begin
            // Issue strobe and final flag live for the single ISSUE cycle only.
            dp_valid_out_reg <= 1'b0;
            dp_final_reg     <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        // Initial AddRoundKey with round key 0 (key_idx is 0 here).
                        state_reg        <= in_data ^ DATA_WIDTH'(key_data);
                        rnd_reg          <= RND_W'(1);
                        in_ready_reg     <= 1'b0;
                        dp_valid_out_reg <= 1'b1;
                        fsm_reg          <= ISSUE;
`ifdef AES_SEQ_KEY256_EN
                        nr_reg           <= in_key_len ? NR_AES256 : NR_AES128;
`endif
                        // nr is at least 10, so round 1 is never the final round.
                    end else begin
                        // in_ready rises one cycle after reset release.
                        in_ready_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    fsm_reg <= WAIT;
                end
                WAIT: begin
                    if (dp_valid_in) begin
                        state_reg <= dp_state_in;
                        if (rnd_reg == nr) begin
                            fsm_reg       <= DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            rnd_reg          <= rnd_next;
                            fsm_reg          <= ISSUE;
                            dp_valid_out_reg <= 1'b1;
                            dp_final_reg     <= (rnd_next == nr);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_reg       <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        rnd_reg       <= '0;
                    end
                end
                default: begin
                    fsm_reg <= IDLE;
                end
            endcase
        end
    end

    // Every output is a register; key_idx tracks the round index, which is 0
    // in IDLE and held through ISSUE/WAIT of each round.
    assign in_ready     = in_ready_reg;
    assign key_idx      = rnd_reg;
    assign dp_valid_out = dp_valid_out_reg;
    assign dp_state_out = state_reg;
    assign dp_final     = dp_final_reg;
    assign out_valid    = out_valid_reg;
    assign out_data     = state_reg;

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES encryption controller. It accepts one plaintext block at a time and performs the initial AddRoundKey itself. It then drives the shared single-round datapath (ShiftRow, SubByte/MixColumn, AddRoundKey) once per round, supplying the round index and round key. It presents the ciphertext through a valid/ready handshake, and sits between the block-level input FIFO and the single-round datapath instance.

## Interface
Parameters:
- DATA_WIDTH, 128, block width
- ROUND_LAT, 1, datapath cycles from `dp_valid_out` to `dp_valid_in` (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  plaintext block offered
- in_ready  out  1  sequencer can accept a block
- in_data  in  DATA_WIDTH  plaintext
- in_key_len  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds)
- key_idx  out  4  round-key index requested from key storage
- key_data  in  128  round key for `key_idx`, combinational, same cycle
- dp_valid_out  out  1  issue one round to datapath
- dp_state_out  out  DATA_WIDTH  state presented to datapath
- dp_final  out  1  current round is last (datapath bypasses MixColumn)
- dp_valid_in  in  1  datapath result valid
- dp_state_in  in  DATA_WIDTH  datapath result
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  DATA_WIDTH  ciphertext

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1 and `key_idx` = 0.
  - On `in_valid & in_ready`: state_reg ← in_data ^ key_data (round key 0), rnd ← 1, nr latched from `in_key_len`. Go to ISSUE.
- ISSUE (exactly one cycle):
  - `dp_valid_out` = 1, `dp_state_out` = state_reg, `key_idx` = rnd, `dp_final` = (rnd == nr). Go to WAIT.
- WAIT:
  - `key_idx` is held at rnd.
  - On `dp_valid_in`: state_reg ← dp_state_in.
  - If rnd == nr, go to DONE. Otherwise rnd ← rnd + 1 and go to ISSUE.
- DONE:
  - `out_valid` = 1 and `out_data` = state_reg, held stable until `out_valid & out_ready`, then go to IDLE.
  - `in_ready` stays 0 in DONE. A new block is accepted no earlier than the cycle after the output handshake.
- `dp_valid_in` outside WAIT is ignored. The datapath never holds more than one block in flight.
- rnd is 4 bits and never exceeds nr. The nr latch changes only on input acceptance.
- `in_key_len` changing mid-block has no effect.
- Asserting `rst` in any state forces IDLE and zeros state_reg, rnd and all outputs. An in-flight block is discarded.

## Timing
- Reset values: in_ready = 0 while `rst` is low, 1 in IDLE after release. `out_valid`, `dp_valid_out` and `dp_final` are 0. `key_idx` is 0. `dp_state_out` and `out_data` are all zeros.
- Per round: 1 + ROUND_LAT cycles.
- Input handshake at cycle 0 → first `dp_valid_out` at cycle 1 → `out_valid` at cycle 1 + nr·(1+ROUND_LAT).
- With ROUND_LAT = 1: AES-128 `out_valid` at cycle 21; AES-256 at cycle 29.
- Throughput: one block per 2 + nr·(1+ROUND_LAT) cycles when the consumer is always ready.
- All outputs are registered or decoded from the FSM state register. There is no combinational path from `in_valid` or `out_ready` to any output except `in_ready`, which is a pure state decode.

## Configuration
- `AES_SEQ_KEY256_EN` defined: `in_key_len` is honoured and nr ∈ {10, 14}.
- `AES_SEQ_KEY256_EN` undefined: `in_key_len` is ignored, nr is fixed at 10, and the nr latch is removed. `key_idx` never exceeds 10.

## Structure
- Shared package `aes_pkg`:
  - FSM state enum `aes_seq_state_t`.
  - Constants NR_AES128 = 10, NR_AES256 = 14.
  - Round-index width constant RND_W = 4.
- Single module; no sub-module. The datapath and key storage are instantiated by the parent and connected through the dp_* and key_* ports.

## Test plan
- AES-128 FIPS-197 C.1, behavioural round model with ROUND_LAT = 1:
  - Stimulus: pt 00112233445566778899aabbccddeeff, key 000102…0f.
  - Response: `out_valid` at cycle 21 with 69c4e0d86a7b0430d8cdb78070b4c55a, and `dp_final` high only on round 10.
- AES-256 FIPS-197 C.3 with `AES_SEQ_KEY256_EN` defined:
  - Stimulus: key 000102…1f.
  - Response: 8ea2b7ca516745bfeafc49904b496089 at cycle 29. `key_idx` steps 0, 1 … 14.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 5 cycles after `out_valid`.
  - Response: `out_data` is stable, `in_ready` stays 0, and the next `in_valid` is accepted the cycle after the handshake.
- Latency sweep: ROUND_LAT = 3 → AES-128 `out_valid` at cycle 41, with the same ciphertext.
- Reset mid-operation:
  - Stimulus: drive `rst` low in WAIT of round 5, then release it.
  - Response: all outputs read their reset values. A fresh C.1 block then completes correctly at cycle 21.
- Spurious `dp_valid_in` pulses in IDLE and DONE: no state change and no output change.
